cond_logic: RTL and testbench

Conditional-execution unit paired with the ALU. It consumes the ALU's `{N,Z,C,V}` flag vector and holds the architectural flags in a register. It evaluates the instruction's 4-bit ARM condition field against those stored flags and gates the datapath write-enables (`PCSrc`, `RegWrite`, `MemWrite`) so that a failed condition has no architectural side effect. It sits between the control decoder and the datapath in the 32-bit ARM core.

---
 rtl/arm_pkg.sv | 34 +++
 rtl/cond_check.sv | 48 ++++
 rtl/cond_logic.sv | 73 +++++++
 tb/tb_cond_logic.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM core definitions: condition-field encodings and the {N,Z,C,V} flag layout.
package arm_pkg;

    typedef logic [3:0] flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW bit assignments: the NZ group and the CV group are written independently.
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: decides whether a condition field
// passes against a given {N,Z,C,V} flag vector. NV (reserved) never passes.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] Cond,
    input  flags_t     Flags,
    output logic       pass
);

    logic  n_f;
    logic  z_f;
    logic  c_f;
    logic  v_f;
    logic  ge;
    cond_e cond;

    assign n_f  = Flags[FLAG_N];
    assign z_f  = Flags[FLAG_Z];
    assign c_f  = Flags[FLAG_C];
    assign v_f  = Flags[FLAG_V];
    assign ge   = (n_f == v_f);
    assign cond = cond_e'(Cond);

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z_f;
            COND_NE: pass = ~z_f;
            COND_CS: pass = c_f;
            COND_CC: pass = ~c_f;
            COND_MI: pass = n_f;
            COND_PL: pass = ~n_f;
            COND_VS: pass = v_f;
            COND_VC: pass = ~v_f;
            COND_HI: pass = c_f & ~z_f;
            COND_LS: pass = ~c_f | z_f;
            COND_GE: pass = ge;
            COND_LT: pass = ~ge;
            COND_GT: pass = ~z_f & ge;
            COND_LE: pass = z_f | ~ge;
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the architectural flags and gates the
// datapath write-enables so a failed condition has no architectural effect.
module cond_logic
    import arm_pkg::*;
#(
    parameter flags_t RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Valid,
    input  logic       Stall,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       Undef,
    output logic [3:0] Flags
);

    flags_t flags_q;
    logic   pass;
    logic   upd_en;
    logic   wr_nz;
    logic   wr_cv;

    // Evaluation uses the registered flags only; a flag write becomes visible next cycle.
    cond_check u_cond_check (
        .Cond  (Cond),
        .Flags (flags_q),
        .pass  (pass)
    );

    assign CondEx = Valid & pass;
    assign Undef  = Valid & (Cond == COND_NV);

    assign upd_en = Valid & ~Stall & CondEx;
    assign wr_nz  = upd_en & FlagW[FLAGW_NZ];
    assign wr_cv  = upd_en & FlagW[FLAGW_CV];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q[FLAG_N] <= RESET_FLAGS[FLAG_N];
            flags_q[FLAG_Z] <= RESET_FLAGS[FLAG_Z];
        end else if (wr_nz) begin
            flags_q[FLAG_N] <= ALUFlags[FLAG_N];
            flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q[FLAG_C] <= RESET_FLAGS[FLAG_C];
            flags_q[FLAG_V] <= RESET_FLAGS[FLAG_V];
        end else if (wr_cv) begin
            flags_q[FLAG_C] <= ALUFlags[FLAG_C];
            flags_q[FLAG_V] <= ALUFlags[FLAG_V];
        end
    end

    // Stall does not gate these; the datapath blocks its own writes while stalled.
    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & ~NoWrite & CondEx;
    assign MemWrite = MemW & CondEx;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic with hand-computed expectations.
module tb_cond_logic;

    logic       clk;
    logic       reset_n;
    logic       Valid;
    logic       Stall;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic       Undef;
    logic [3:0] Flags;

    int chk_cnt;
    int pass_cnt;

    cond_logic dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Valid    (Valid),
        .Stall    (Stall),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Undef    (Undef),
        .Flags    (Flags)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        Valid = 0; Stall = 0; Cond = 4'b1110; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    endtask

    // advance one clock edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        chk_cnt = 0;
        pass_cnt = 0;
        idle();
        reset_n = 0;
        #1;
        // reset state and zero-latency outputs under reset
        check("rst_flags", {4'b0, Flags}, 8'h00);
        Valid = 1; Cond = 4'b0000;
        #1 check("rst_eq_condex", {7'b0, CondEx}, 8'h00);
        Cond = 4'b1110; RegW = 1;
        #1 check("rst_al_regwrite", {7'b0, RegWrite}, 8'h01);
        Valid = 0;
        #1 check("rst_bubble_regwrite", {7'b0, RegWrite}, 8'h00);
        // write attempt while reset is held must be discarded
        Valid = 1; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        check("rst_hold_flags", {4'b0, Flags}, 8'h00);
        idle();
        @(negedge clk);
        reset_n = 1;
        tick();
        check("post_rst_flags", {4'b0, Flags}, 8'h00);

        // group write: NZ only
        Valid = 1; Cond = 4'b1110; ALUFlags = 4'b0100; FlagW = 2'b10;
        tick();
        check("nz_write", {4'b0, Flags}, 8'h04);
        FlagW = 0; ALUFlags = 0; Cond = 4'b0000; MemW = 1;
        #1 check("eq_memwrite", {7'b0, MemWrite}, 8'h01);
        Cond = 4'b0001;
        #1 check("ne_memwrite", {7'b0, MemWrite}, 8'h00);
        MemW = 0;

        // independent CV group write
        Cond = 4'b1110; ALUFlags = 4'b1011; FlagW = 2'b01;
        tick();
        check("cv_write", {4'b0, Flags}, 8'h07);
        FlagW = 0;
        Cond = 4'b1000; #1 check("hi_condex", {7'b0, CondEx}, 8'h00);
        Cond = 4'b1010; #1 check("ge_condex", {7'b0, CondEx}, 8'h00);
        Cond = 4'b1011; #1 check("lt_condex", {7'b0, CondEx}, 8'h01);
        Cond = 4'b1100; #1 check("gt_condex", {7'b0, CondEx}, 8'h00);
        Cond = 4'b1101; #1 check("le_condex", {7'b0, CondEx}, 8'h01);
        Cond = 4'b1001; #1 check("ls_condex", {7'b0, CondEx}, 8'h01);
        Cond = 4'b0100; #1 check("mi_condex", {7'b0, CondEx}, 8'h00);
        Cond = 4'b0101; #1 check("pl_condex", {7'b0, CondEx}, 8'h01);
        Cond = 4'b0110; #1 check("vs_condex", {7'b0, CondEx}, 8'h01);
        Cond = 4'b0011; #1 check("cc_condex", {7'b0, CondEx}, 8'h00);

        // async reset back to 0000
        reset_n = 0;
        #1 check("async_rst_flags", {4'b0, Flags}, 8'h00);
        reset_n = 1;
        tick();

        // failed condition blocks flag write and all gated writes
        Valid = 1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
        PCS = 1; RegW = 1; MemW = 1;
        #1 check("fail_gates", {5'b0, PCSrc, RegWrite, MemWrite}, 8'h00);
        tick();
        check("fail_gates_post", {5'b0, PCSrc, RegWrite, MemWrite}, 8'h00);
        check("fail_flags", {4'b0, Flags}, 8'h00);
        PCS = 0; RegW = 0; MemW = 0;

        // stall blocks update though the condition passes
        Cond = 4'b1110; ALUFlags = 4'b1010; FlagW = 2'b11; Stall = 1; PCS = 1;
        #1 check("stall_pcsrc", {6'b0, PCSrc, Undef}, 8'h02);
        tick();
        check("stall_flags", {4'b0, Flags}, 8'h00);
        Stall = 0; PCS = 0;
        // bubble blocks update
        Valid = 0; Cond = 4'b1111;
        #1 check("bubble_undef", {6'b0, Undef, CondEx}, 8'h00);
        tick();
        check("bubble_flags", {4'b0, Flags}, 8'h00);
        // undef blocks update
        Valid = 1;
        #1 check("undef_flag", {6'b0, Undef, CondEx}, 8'h02);
        tick();
        check("undef_flags", {4'b0, Flags}, 8'h00);

        // compare-class: writes flags, never RegWrite
        Cond = 4'b1110; NoWrite = 1; RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0110;
        #1 check("cmp_regwrite", {6'b0, RegWrite, CondEx}, 8'h01);
        tick();
        check("cmp_flags", {4'b0, Flags}, 8'h06);
        idle();
        // next-cycle visibility of the new Z
        Valid = 1; Cond = 4'b0000;
        #1 check("cmp_eq_visible", {7'b0, CondEx}, 8'h01);
        // mid-cycle reset pulse clears without an edge
        @(negedge clk);
        reset_n = 0;
        #1 check("pulse_rst_flags", {4'b0, Flags}, 8'h00);
        #1 reset_n = 1;
        #1 check("pulse_rst_hold", {4'b0, Flags}, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
